// File: rtl/clk_prescaler_down_pkg.sv
// Shared constants for the programmable clock prescaler: FSM state encoding
// and the default counter width / half-period used by clk_prescaler_down.
package clk_prescaler_down_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int PRESC_WIDTH       = 8;
  localparam int PRESC_DEFAULT_DIV = 4;

endpackage

// File: rtl/clk_prescaler_down.sv
// Programmable synchronous prescaler. Produces a registered, glitch-free
// divided clock (period 2*div) for a downstream ripple stage, plus a one-cycle
// tick on every divided-clock toggle. The half-period is held in a loadable
// register and counted out by an internal down-counter.
//
// Optional build macro PRESCALER_HOLD_HIGH_EN: when defined, dropping en while
// the divided clock is low finishes the current half-period (DRAIN) so the
// downstream stage always stops with its clock high. When undefined, dropping
// en freezes the divided clock and count immediately.
module clk_prescaler_down
  import clk_prescaler_down_pkg::*;
#(
  parameter int WIDTH       = PRESC_WIDTH,
  parameter int DEFAULT_DIV = PRESC_DEFAULT_DIV
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             CLK_OUT,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic             clk_q,   clk_d;
  logic             tick_q,  tick_d;
  logic [WIDTH-1:0] ld_val;

  // A requested half-period of zero is meaningless; run it as one cycle.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  assign ld_val = clamp_div(div_val);

  // Next-state logic for the FSM, down-counter, divide register and toggle flop.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Starting uses the divide value already registered; a same-cycle
        // load only takes effect from the next reload.
        if (load) div_d = ld_val;
        if (en) begin
          state_d = ST_RUN;
          count_d = div_q - WIDTH'(1);
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (load) begin
          div_d   = ld_val;
          count_d = ld_val - WIDTH'(1);
        end else if (count_q == '0) begin
          count_d = div_q - WIDTH'(1);
          clk_d   = ~clk_q;
          tick_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
`ifdef PRESCALER_HOLD_HIGH_EN
        if (en) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && clk_q) begin
          // Clock already high: stop right here with everything frozen.
          state_d = ST_IDLE;
          count_d = count_q;
          clk_d   = clk_q;
          tick_d  = 1'b0;
        end else if (clk_d) begin
          // The rising toggle that ends the low half-period completes the stop.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
`else
        if (!en) begin
          state_d = ST_IDLE;
          count_d = count_q;
          clk_d   = clk_q;
          tick_d  = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drives the divided clock high and reloads the default divide.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      div_q   <= WIDTH'(DEFAULT_DIV);
      clk_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign CLK_OUT = clk_q;
  assign tick    = tick_q;
  assign count   = count_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_prescaler_down.sv
// Testbench for clk_prescaler_down: directed scenarios followed by random
// enable/load/reset traffic. A reference model predicts each cycle's outputs
// into a queue; an independent monitor pops and compares on the falling edge.
module tb_clk_prescaler_down;

  localparam int W   = 8;
  localparam int DEF = 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         en;
  logic         load;
  logic [W-1:0] div_val;
  logic         CLK_OUT;
  logic         tick;
  logic [W-1:0] count;
  logic         busy;

  clk_prescaler_down #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .en     (en),
    .load   (load),
    .div_val(div_val),
    .CLK_OUT(CLK_OUT),
    .tick   (tick),
    .count  (count),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit clk;
    bit tck;
    int cnt;
    bit bsy;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  // Mode: 0 stopped, 1 running, 2 finishing a low half-period.
  // While running, el counts edges elapsed in the current half-period of
  // length iv; the edge on which el reaches iv-1 is the toggle edge.
  int m_div, m_iv, m_el, m_hold, m_mode;
  bit m_clk, m_tick;

  function automatic int clampi(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int m_count();
    return (m_mode == 0) ? m_hold : (m_iv - 1 - m_el);
  endfunction

  always @(posedge CLK) begin : model
    int nd;
    int prev_cnt;
    bit prev_clk;
    bit stop_now;
    exp_t e;
    if (!RST_N) begin
      m_div = DEF; m_iv = DEF; m_el = 0; m_hold = 0;
      m_mode = 0; m_clk = 1'b1; m_tick = 1'b0;
    end else begin
      nd       = clampi(int'(div_val));
      prev_cnt = m_count();
      prev_clk = m_clk;
      m_tick   = 1'b0;
      if (m_mode == 0) begin
        if (en) begin
          m_mode = 1; m_iv = m_div; m_el = 0;
        end
        if (load) m_div = nd;
      end else begin
        stop_now = 1'b0;
`ifdef PRESCALER_HOLD_HIGH_EN
        if (m_mode == 1 && !en && prev_clk) stop_now = 1'b1;
`else
        if (!en) stop_now = 1'b1;
`endif
        if (stop_now) begin
          if (load) m_div = nd;
          m_hold = prev_cnt;
          m_mode = 0;
        end else begin
          if (load) begin
            m_div = nd; m_iv = nd; m_el = 0;
          end else if (m_el == m_iv - 1) begin
            m_clk = ~m_clk; m_tick = 1'b1; m_iv = m_div; m_el = 0;
          end else begin
            m_el++;
          end
`ifdef PRESCALER_HOLD_HIGH_EN
          if (en) m_mode = 1;
          else if (m_clk) begin
            m_hold = m_iv - 1 - m_el;
            m_mode = 0;
          end else m_mode = 2;
`endif
        end
      end
      e.clk = m_clk;
      e.tck = m_tick;
      e.cnt = m_count();
      e.bsy = (m_mode != 0);
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RST_N) begin
      exp_q.delete();
      check("rst_clk_out", int'(CLK_OUT), 1);
      check("rst_tick",    int'(tick),    0);
      check("rst_count",   int'(count),   0);
      check("rst_busy",    int'(busy),    0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_out", int'(CLK_OUT), int'(e.clk));
      check("tick",    int'(tick),    int'(e.tck));
      check("count",   int'(count),   e.cnt);
      check("busy",    int'(busy),    int'(e.bsy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Asserted between edges: outputs must already be at reset values 1ns later.
  task automatic pulse_reset();
    #2 RST_N = 1'b0;
    #1;
    check("async_clk_out", int'(CLK_OUT), 1);
    check("async_tick",    int'(tick),    0);
    check("async_count",   int'(count),   0);
    check("async_busy",    int'(busy),    0);
    @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  task automatic do_load(input int v);
    @(negedge CLK);
    load = 1'b1; div_val = W'(v);
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic wait_count(input int v, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      if (int'(count) == v) hit = 1'b1;
    end
    check(name, int'(hit), 1);
  endtask

  task automatic wait_fall(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      if (!CLK_OUT && tick) hit = 1'b1;
    end
    check("wait_fall", int'(hit), 1);
  endtask

  initial begin
    RST_N = 1'b0; en = 1'b0; load = 1'b0; div_val = '0;
    cycles(3);
    #2 RST_N = 1'b1;

    // Default divide: toggle every 4 edges.
    cycles(2);
    en = 1'b1;
    cycles(20);

    // Divide value 0 behaves as 1.
    do_load(0);
    cycles(8);

    // Reload mid-count at count 3 with a shorter divide.
    do_load(6);
    wait_count(3, 30, "wait_cnt3");
    load = 1'b1; div_val = W'(2);
    @(negedge CLK);
    load = 1'b0;
    cycles(10);

    // Drop en just after the divided clock falls.
    do_load(3);
    wait_fall(30);
    en = 1'b0;
    cycles(8);
    en = 1'b1;
    cycles(6);

    // Load while idle, then resume.
    en = 1'b0;
    cycles(2);
    do_load(2);
    en = 1'b1;
    cycles(10);

    // Asynchronous reset mid-run with div 5 at count 2.
    do_load(5);
    wait_count(2, 30, "wait_cnt2");
    pulse_reset();
    cycles(12);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      en   = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) div_val = W'($urandom_range(0, 40));
      else                           div_val = W'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end
    en = 1'b0; load = 1'b0;
    cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
